// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared register addresses and the hex-to-segment decode table.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam logic [11:0] SEG7_ADDR_DATA = 12'h000;
    localparam logic [11:0] SEG7_ADDR_MASK = 12'h004;

    // Active-low {dp,g,f,e,d,c,b,a}; entry [0] is the rightmost element.
    localparam logic [15:0][7:0] SEG7_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg7_lookup(input logic [3:0] hex);
        return SEG7_TABLE[hex];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_display_if.sv
// ============================================================================
// Module  : seg7_display_if
// Purpose : Register bus and display outputs of the 8-digit 7-segment driver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_display_if;
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  led_en;
    logic [7:0]  seg;

    modport master (
        output addr, we, wdata,
        input  rdata, led_en, seg
    );

    modport slave (
        input  addr, we, wdata,
        output rdata, led_en, seg
    );
endinterface

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module  : seg7_decoder
// Purpose : Combinational hex digit to active-low segment pattern, dp off.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decoder
    import seg7_pkg::*;
(
    input  wire logic [3:0] hex_i,
    output wire logic [7:0] seg_o
);

    logic [7:0] w_raw;

    assign w_raw = seg7_lookup(hex_i);
    assign seg_o = {1'b1, w_raw[6:0]};

endmodule

`default_nettype wire

// File: rtl/seg7_display.sv
// ============================================================================
// Module  : seg7_display
// Purpose : Register-mapped, time-multiplexed 8-digit 7-segment display driver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_display
    import seg7_pkg::*;
#(
    parameter int          SCAN_DIV  = 20000,
    parameter logic [11:0] ADDR_DATA = SEG7_ADDR_DATA,
    parameter logic [11:0] ADDR_MASK = SEG7_ADDR_MASK
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    seg7_display_if.slave   bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_q,  data_d;
    logic [7:0]       mask_q,  mask_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [7:0]       led_q,   led_d;
    logic [7:0]       seg_q,   seg_d;

    logic [3:0]       w_nibble;
    logic [7:0]       w_dec;
    logic             w_wrap;

    assign w_nibble = data_q[{idx_q, 2'b00} +: 4];
    assign w_wrap   = (cnt_q == CNT_LAST);

    seg7_decoder u_decoder (
        .hex_i (w_nibble),
        .seg_o (w_dec)
    );

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (bus.we && (bus.addr == ADDR_DATA)) begin
            data_d = bus.wdata;
        end
        if (bus.we && (bus.addr == ADDR_MASK)) begin
            mask_d = bus.wdata[7:0];
        end

        // Readback uses the pre-write register contents.
        if (bus.addr == ADDR_DATA) begin
            rdata_d = data_q;
        end else if (bus.addr == ADDR_MASK) begin
            rdata_d = {24'h0, mask_q};
        end else begin
            rdata_d = 32'h0;
        end

        cnt_d = w_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = w_wrap ? idx_q + 3'd1 : idx_q;

        if (mask_q[idx_q]) begin
            led_d = 8'hFF;
            seg_d = 8'hFF;
        end else begin
            led_d = ~(8'h01 << idx_q);
            seg_d = w_dec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= 32'h0;
            mask_q  <= 8'h00;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            rdata_q <= 32'h0;
            led_q   <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.led_en = led_q;
    assign bus.seg    = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_display.sv
// ============================================================================
// Module  : tb_seg7_display
// Purpose : Randomized, model-checked bench for seg7_display with SCAN_DIV=4.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_display;

    localparam int SCAN = 4;
    localparam logic [7:0] TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seg7_display_if bus ();

    seg7_display #(.SCAN_DIV(SCAN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: digit index follows from the edge count since reset.
    bit          valid;
    logic [31:0] m_data;
    logic [7:0]  m_mask;
    int          m_t;
    logic [31:0] e_rdata;
    logic [7:0]  e_led;
    logic [7:0]  e_seg;

    always @(posedge clk) begin
        int idx;
        if (rst) begin
            valid   = 1'b1;
            m_data  = 32'h0;
            m_mask  = 8'h00;
            m_t     = 0;
            e_rdata = 32'h0;
            e_led   = 8'hFF;
            e_seg   = 8'hFF;
        end else if (valid) begin
            idx = (m_t / SCAN) % 8;
            case (bus.addr)
                12'h000: e_rdata = m_data;
                12'h004: e_rdata = {24'h0, m_mask};
                default: e_rdata = 32'h0;
            endcase
            if (m_mask[idx]) begin
                e_led = 8'hFF;
                e_seg = 8'hFF;
            end else begin
                e_led      = 8'hFF;
                e_led[idx] = 1'b0;
                e_seg      = TAB[(m_data >> (4 * idx)) & 32'hF];
            end
            if (bus.we && bus.addr == 12'h000) m_data = bus.wdata;
            if (bus.we && bus.addr == 12'h004) m_mask = bus.wdata[7:0];
            m_t++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (valid) begin
            check("rdata",  bus.rdata,  e_rdata);
            check("led_en", {24'h0, bus.led_en}, {24'h0, e_led});
            check("seg",    {24'h0, bus.seg},    {24'h0, e_seg});
            check("one_digit", {31'h0, $countones(~bus.led_en) <= 1}, 32'h1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_led(input logic [7:0] v, input string name);
        int n;
        n = 0;
        while (bus.led_en !== v && n < 80) begin
            tick();
            n++;
        end
        if (n >= 80) check({name, "_timeout"}, {24'h0, bus.led_en}, {24'h0, v});
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.we    = 1'b1;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        valid     = 1'b0;
        rst       = 1'b1;
        bus.addr  = 12'h000;
        bus.we    = 1'b0;
        bus.wdata = 32'h0;
        repeat (3) tick();
        check("rst_led", {24'h0, bus.led_en}, 32'hFF);
        check("rst_seg", {24'h0, bus.seg}, 32'hFF);
        check("rst_rdata", bus.rdata, 32'h0);

        rst = 1'b0;
        tick();
        check("first_led", {24'h0, bus.led_en}, 32'hFE);
        check("first_seg", {24'h0, bus.seg}, 32'hC0);
        repeat (4) tick();
        check("dwell_led", {24'h0, bus.led_en}, 32'hFD);
        repeat (30) tick();

        wr(12'h000, 32'h89ABCDEF);
        tick();
        check("read_data", bus.rdata, 32'h89ABCDEF);
        wait_led(8'hFE, "idx0");
        check("seg_idx0", {24'h0, bus.seg}, 32'h8E);
        wait_led(8'h7F, "idx7");
        check("seg_idx7", {24'h0, bus.seg}, 32'h80);

        wr(12'h004, 32'hFFFFFF0F);
        bus.addr = 12'h004;
        tick();
        check("read_mask", bus.rdata, 32'h0000000F);
        wait_led(8'hEF, "idx4");
        check("seg_idx4", {24'h0, bus.seg}, 32'h83);

        bus.addr  = 12'h000;
        bus.we    = 1'b1;
        bus.wdata = 32'h12345678;
        tick();
        bus.we    = 1'b0;
        check("rw_old", bus.rdata, 32'h89ABCDEF);
        tick();
        check("rw_new", bus.rdata, 32'h12345678);

        wait_led(8'hDF, "idx5");
        tick();
        rst       = 1'b1;
        bus.we    = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        repeat (2) tick();
        check("mid_rst_led", {24'h0, bus.led_en}, 32'hFF);
        check("mid_rst_seg", {24'h0, bus.seg}, 32'hFF);
        rst    = 1'b0;
        bus.we = 1'b0;
        tick();
        check("resume_led", {24'h0, bus.led_en}, 32'hFE);
        check("resume_seg", {24'h0, bus.seg}, 32'hC0);
        check("dropped_wr", bus.rdata, 32'h0);

        wr(12'h000, 32'h13579BDF);
        wr(12'h004, 32'h00000022);
        wr(12'h070, 32'hFFFFFFFF);
        bus.addr = 12'h070;
        tick();
        check("read_other", bus.rdata, 32'h0);
        bus.addr = 12'h000;
        tick();
        check("other_data", bus.rdata, 32'h13579BDF);
        bus.addr = 12'h004;
        tick();
        check("other_mask", bus.rdata, 32'h00000022);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3, 0))
                0: bus.addr = 12'h000;
                1: bus.addr = 12'h004;
                2: bus.addr = 12'h070;
                default: bus.addr = 12'($urandom);
            endcase
            bus.we    = ($urandom_range(3, 0) == 0);
            bus.wdata = $urandom;
            rst       = ($urandom_range(99, 0) == 0);
            tick();
        end
        rst    = 1'b0;
        bus.we = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
